// File: rtl/axi_rd_fsm.sv
// AXI4 read slave that streams beats from one of two show-ahead FIFOs.
// Address bits [15:12] pick the source; other source codes return DECERR.
module axi_rd_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  axs_s0_arid,
   input  logic [31:0] axs_s0_araddr,
   input  logic [7:0]  axs_s0_arlen,
   input  logic [2:0]  axs_s0_arsize,
   input  logic [1:0]  axs_s0_arburst,
   input  logic        axs_s0_arvalid,
   output logic        axs_s0_arready,
   output logic [3:0]  axs_s0_rid,
   output logic [31:0] axs_s0_rdata,
   output logic [1:0]  axs_s0_rresp,
   output logic        axs_s0_rlast,
   output logic        axs_s0_rvalid,
   input  logic        axs_s0_rready,
   input  logic        varint_out_fifo_empty,
   input  logic [31:0] varint_out_fifo_data,
   output logic        varint_out_fifo_pop,
   input  logic        raw_data_out_fifo_empty,
   input  logic [31:0] raw_data_out_fifo_data,
   output logic        raw_data_out_fifo_pop
);

   typedef enum logic [1:0] {
      INIT,
      AR_READY,
      R_FETCH,
      R_VALID
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t      state_q, state_d;
   logic [3:0]  id_q, id_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  beat_q, beat_d;
   logic        sel_raw_q, sel_raw_d;
   logic [1:0]  resp_q, resp_d;
   logic [31:0] rdata_q, rdata_d;

   logic arready_c;
   logic rvalid_c;
   logic rlast_c;
   logic vpop_c;
   logic rpop_c;

   logic unused_bits;
   assign unused_bits = ^{axs_s0_arburst,
                          axs_s0_araddr[31:16],
                          axs_s0_araddr[11:0]};

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      len_d     = len_q;
      beat_d    = beat_q;
      sel_raw_d = sel_raw_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      arready_c = 1'b0;
      rvalid_c  = 1'b0;
      rlast_c   = 1'b0;
      vpop_c    = 1'b0;
      rpop_c    = 1'b0;
      unique case (state_q)
         INIT: begin
            state_d = AR_READY;
         end
         AR_READY: begin
            arready_c = 1'b1;
            if (axs_s0_arvalid) begin
               id_d      = axs_s0_arid;
               len_d     = axs_s0_arlen;
               beat_d    = 8'd0;
               sel_raw_d = axs_s0_araddr[12];
               if (axs_s0_araddr[15:13] != 3'd0)
                  resp_d = RESP_DECERR;
               else if (axs_s0_arsize != 3'b010)
                  resp_d = RESP_SLVERR;
               else
                  resp_d = RESP_OKAY;
               state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            if (resp_q != RESP_OKAY) begin
               rdata_d = 32'd0;
               state_d = R_VALID;
            end else if (sel_raw_q) begin
               if (!raw_data_out_fifo_empty) begin
                  rpop_c  = 1'b1;
                  rdata_d = raw_data_out_fifo_data;
                  state_d = R_VALID;
               end
            end else begin
               if (!varint_out_fifo_empty) begin
                  vpop_c  = 1'b1;
                  rdata_d = varint_out_fifo_data;
                  state_d = R_VALID;
               end
            end
         end
         R_VALID: begin
            rvalid_c = 1'b1;
            rlast_c  = (beat_q == len_q);
            if (axs_s0_rready) begin
               if (rlast_c) begin
                  state_d = AR_READY;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  state_d = R_FETCH;
               end
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= INIT;
         id_q      <= 4'd0;
         len_q     <= 8'd0;
         beat_q    <= 8'd0;
         sel_raw_q <= 1'b0;
         resp_q    <= RESP_OKAY;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         sel_raw_q <= sel_raw_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
      end
   end

   // Reset gates the handshake/pop strobes immediately, before the edge.
   assign axs_s0_arready        = arready_c & ~reset;
   assign axs_s0_rvalid         = rvalid_c & ~reset;
   assign axs_s0_rlast          = rlast_c & ~reset;
   assign varint_out_fifo_pop   = vpop_c & ~reset;
   assign raw_data_out_fifo_pop = rpop_c & ~reset;
   assign axs_s0_rid            = id_q;
   assign axs_s0_rdata          = rdata_q;
   assign axs_s0_rresp          = resp_q;

endmodule

// File: tb/tb_axi_rd_fsm.sv
// Directed bench for axi_rd_fsm with queue-backed show-ahead FIFOs.
module tb_axi_rd_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = 3'b010;
   logic [1:0]  arburst = 2'b01;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b1;
   logic        v_empty = 1'b1;
   logic [31:0] v_data = '0;
   logic        v_pop;
   logic        r_empty = 1'b1;
   logic [31:0] r_data = '0;
   logic        r_pop;

   logic [31:0] vq[$];
   logic [31:0] rq[$];
   int v_pops = 0;
   int r_pops = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_rd_fsm dut (
      .clk                     (clk),
      .reset                   (reset),
      .axs_s0_arid             (arid),
      .axs_s0_araddr           (araddr),
      .axs_s0_arlen            (arlen),
      .axs_s0_arsize           (arsize),
      .axs_s0_arburst          (arburst),
      .axs_s0_arvalid          (arvalid),
      .axs_s0_arready          (arready),
      .axs_s0_rid              (rid),
      .axs_s0_rdata            (rdata),
      .axs_s0_rresp            (rresp),
      .axs_s0_rlast            (rlast),
      .axs_s0_rvalid           (rvalid),
      .axs_s0_rready           (rready),
      .varint_out_fifo_empty   (v_empty),
      .varint_out_fifo_data    (v_data),
      .varint_out_fifo_pop     (v_pop),
      .raw_data_out_fifo_empty (r_empty),
      .raw_data_out_fifo_data  (r_data),
      .raw_data_out_fifo_pop   (r_pop)
   );

   task automatic refresh();
      v_empty = (vq.size() == 0);
      v_data  = (vq.size() == 0) ? 32'd0 : vq[0];
      r_empty = (rq.size() == 0);
      r_data  = (rq.size() == 0) ? 32'd0 : rq[0];
   endtask

   always @(posedge clk) begin
      if (v_pop) begin
         v_pops++;
         if (vq.size() != 0) void'(vq.pop_front());
      end
      if (r_pop) begin
         r_pops++;
         if (rq.size() != 0) void'(rq.pop_front());
      end
      refresh();
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [2:0] sz);
      int n;
      @(negedge clk);
      araddr = a; arid = id; arlen = len; arsize = sz;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!arready) check("ar_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 arvalid = 1'b0;
   endtask

   task automatic get_beat(output logic [31:0] d, output logic [1:0] r,
                           output logic l, output logic [3:0] id,
                           output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rvalid && lat < 50);
      if (!rvalid) check("r_timeout", 32'd0, 32'd1);
      d = rdata; r = rresp; l = rlast; id = rid;
   endtask

   logic [31:0] d;
   logic [1:0]  r;
   logic        l;
   logic [3:0]  id;
   int lat, vp0, rp0, first_last, nbeats;

   initial begin
      refresh();
      repeat (3) @(negedge clk);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rlast", {31'd0, rlast}, 32'd0);
      check("rst_rresp", {30'd0, rresp}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rid", {28'd0, rid}, 32'd0);
      check("rst_pops", {30'd0, v_pop, r_pop}, 32'd0);
      reset = 1'b0;
      #1 check("init_arready", {31'd0, arready}, 32'd0);
      @(negedge clk);
      check("ready_arready", {31'd0, arready}, 32'd1);

      // single varint beat
      vq.push_back(32'hDEADBEEF); refresh();
      vp0 = v_pops; rp0 = r_pops;
      send_ar(32'h0000, 4'd6, 8'd0, 3'b010);
      get_beat(d, r, l, id, lat);
      check("s_lat", lat, 2);
      check("s_data", d, 32'hDEADBEEF);
      check("s_rid", {28'd0, id}, 32'd6);
      check("s_resp", {30'd0, r}, 32'd0);
      check("s_last", {31'd0, l}, 32'd1);
      @(negedge clk);
      check("s_back_ready", {31'd0, arready}, 32'd1);
      check("s_vpops", v_pops - vp0, 1);
      check("s_rpops", r_pops - rp0, 0);

      // raw burst of 4
      for (int i = 1; i <= 4; i++) rq.push_back(i);
      refresh();
      vp0 = v_pops; rp0 = r_pops;
      send_ar(32'h1000, 4'd3, 8'd3, 3'b010);
      for (int i = 0; i < 4; i++) begin
         get_beat(d, r, l, id, lat);
         check($sformatf("raw_data%0d", i), d, i + 1);
         check($sformatf("raw_last%0d", i), {31'd0, l}, (i == 3) ? 1 : 0);
         if (i == 1) check("raw_beat_lat", lat, 2);
      end
      @(negedge clk);
      check("raw_rpops", r_pops - rp0, 4);
      check("raw_vpops", v_pops - vp0, 0);

      // backpressure then empty FIFO mid-burst
      vq.push_back(32'hA1); vq.push_back(32'hA2); refresh();
      vp0 = v_pops;
      rready = 1'b0;
      send_ar(32'h0000, 4'd9, 8'd2, 3'b010);
      get_beat(d, r, l, id, lat);
      check("bp_data", d, 32'hA1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rvalid", {31'd0, rvalid}, 32'd1);
         check("bp_rdata", rdata, 32'hA1);
      end
      check("bp_vpops", v_pops - vp0, 1);
      rready = 1'b1;
      get_beat(d, r, l, id, lat);
      check("bp_data2", d, 32'hA2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("emp_rvalid", {31'd0, rvalid}, 32'd0);
         check("emp_pop", {31'd0, v_pop}, 32'd0);
      end
      vq.push_back(32'hA3); refresh();
      get_beat(d, r, l, id, lat);
      check("emp_data3", d, 32'hA3);
      check("emp_last3", {31'd0, l}, 32'd1);
      @(negedge clk);
      check("emp_vpops", v_pops - vp0, 3);

      // error responses, varint FIFO non-empty throughout
      vq.push_back(32'h55); refresh();
      vp0 = v_pops; rp0 = r_pops;
      send_ar(32'h2000, 4'd1, 8'd0, 3'b010);
      get_beat(d, r, l, id, lat);
      check("dec_resp", {30'd0, r}, 32'd3);
      check("dec_data", d, 32'd0);
      check("dec_last", {31'd0, l}, 32'd1);
      send_ar(32'h0000, 4'd2, 8'd2, 3'b001);
      for (int i = 0; i < 3; i++) begin
         get_beat(d, r, l, id, lat);
         check("slv_resp", {30'd0, r}, 32'd2);
         check("slv_data", d, 32'd0);
         check("slv_last", {31'd0, l}, (i == 2) ? 1 : 0);
      end
      send_ar(32'h2000, 4'd4, 8'd0, 3'b001);
      get_beat(d, r, l, id, lat);
      check("dec_prio", {30'd0, r}, 32'd3);
      @(negedge clk);
      check("err_pops", (v_pops - vp0) + (r_pops - rp0), 0);

      // 256-beat burst
      first_last = -1; nbeats = 0;
      send_ar(32'h0000, 4'd5, 8'd255, 3'b000);
      for (int i = 0; i < 256; i++) begin
         get_beat(d, r, l, id, lat);
         nbeats++;
         if (l && first_last < 0) first_last = i;
      end
      check("l255_first_last", first_last, 255);
      @(negedge clk);
      check("l255_ready", {31'd0, arready}, 32'd1);

      // reset during beat 2 of an 8-beat raw burst
      rq.delete();
      for (int i = 0; i < 8; i++) rq.push_back(32'h10 + i);
      refresh();
      rp0 = r_pops;
      send_ar(32'h1000, 4'd7, 8'd7, 3'b010);
      get_beat(d, r, l, id, lat);
      get_beat(d, r, l, id, lat);
      check("mr_beat2", d, 32'h11);
      reset = 1'b1;
      #1;
      check("mr_rvalid0", {31'd0, rvalid}, 32'd0);
      check("mr_pop0", {31'd0, r_pop}, 32'd0);
      @(negedge clk);
      check("mr_rvalid1", {31'd0, rvalid}, 32'd0);
      check("mr_rdata1", rdata, 32'd0);
      check("mr_pop1", {30'd0, v_pop, r_pop}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("mr_init", {31'd0, arready}, 32'd0);
      @(negedge clk);
      check("mr_ready", {31'd0, arready}, 32'd1);
      check("mr_rpops", r_pops - rp0, 2);
      check("mr_rvalid2", {31'd0, rvalid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/axi_rd_fsm.md
AXI_RD_FSM -- requirements
Module: axi_rd_fsm

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 axs_s0_arid  input  4  read transaction ID.
REQ-005 axs_s0_araddr  input  32  read address; [15:12] selects source.
REQ-006 axs_s0_arlen  input  8  beats minus one.
REQ-007 axs_s0_arsize  input  3  beat size; only 3'b010 is legal.
REQ-008 axs_s0_arburst  input  2  burst type; ignored, FIFO address is fixed.
REQ-009 axs_s0_arvalid / axs_s0_arready  input / output  1 / 1  AR handshake.
REQ-010 axs_s0_rid  output  4  latched arid.
REQ-011 axs_s0_rdata  output  32  registered read data.
REQ-012 axs_s0_rresp  output  2  response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-013 axs_s0_rlast / axs_s0_rvalid / axs_s0_rready  output / output / input  1 each  R channel.
REQ-014 varint_out_fifo_empty, varint_out_fifo_data, varint_out_fifo_pop  input 1, input 32, output 1  show-ahead decoded-varint FIFO.
REQ-015 raw_data_out_fifo_empty, raw_data_out_fifo_data, raw_data_out_fifo_pop  input 1, input 32, output 1  show-ahead raw-data FIFO.

Function
REQ-016 States SHALL be INIT, AR_READY, R_FETCH, R_VALID.
REQ-017 INIT SHALL last exactly one cycle after reset deasserts, then go to AR_READY.
REQ-018 arready SHALL be 1 only in AR_READY.
REQ-019 On arvalid&&arready, the block SHALL latch arid, arlen, and the select and response code, clear the beat counter, and go to R_FETCH.
REQ-020 Select decode SHALL be: araddr[15:12]==0 -> varint, ==1 -> raw, else DECERR; arsize!=3'b010 -> SLVERR. DECERR takes priority over SLVERR.
REQ-021 R_FETCH with OKAY and the selected FIFO not empty SHALL assert that FIFO's pop for exactly one cycle, load rdata from its head, and go to R_VALID next cycle.
REQ-022 R_FETCH with the selected FIFO empty SHALL hold without popping, with rvalid=0, until the FIFO is non-empty.
REQ-023 R_FETCH with SLVERR/DECERR SHALL load rdata=0 and go to R_VALID; it SHALL never pop.
REQ-024 The unselected FIFO SHALL never be popped; at most one pop SHALL be high per cycle.
REQ-025 R_VALID SHALL drive rvalid=1 and rresp=latched code. rlast SHALL be 1 when beat count == latched arlen.
REQ-026 rdata, rid, rresp and rlast SHALL stay stable while rvalid && !rready.
REQ-027 On rready in R_VALID: if rlast, go to AR_READY; else increment the 8-bit beat counter and go to R_FETCH.
REQ-028 Throughput SHALL be one beat per two cycles minimum. arvalid-to-first-rvalid latency SHALL be 2 cycles when the FIFO is non-empty.
REQ-029 arlen=255 SHALL produce 256 beats with no counter wrap before rlast.
REQ-030 arvalid in any state other than AR_READY SHALL be ignored; there is no outstanding-transaction queue.

Reset
REQ-031 While reset=1 the block SHALL set state=INIT and drive arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, rid=0, both pops=0, beat counter=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst at the next edge. No further pops SHALL occur, and the current beat is discarded.

Verification
REQ-033 Single beat: araddr=0x0000, arid=6, arlen=0, varint head=0xDEADBEEF -> one varint pop; rdata=0xDEADBEEF, rid=6, rresp=00, rlast=1; return to AR_READY.
REQ-034 Raw burst: araddr=0x1000, arlen=3, raw FIFO holds 1,2,3,4 -> exactly 4 raw pops and 0 varint pops; rlast only on data 4.
REQ-035 Backpressure and empty: rready held low 5 cycles -> rvalid and rdata stable, no extra pop. Selected FIFO empty 3 cycles mid-burst -> rvalid=0 and no pop until non-empty.
REQ-036 Errors: araddr=0x2000 -> rresp=11, rdata=0, no pops. arsize=3'b001 at araddr 0x0000 -> rresp=10, arlen+1 beats, no pops.
REQ-037 Reset asserted during beat 2 of an arlen=7 burst -> rvalid=0 and pops=0 from the next edge; INIT then AR_READY after reset is released.
